// File: rtl/edge_pkg.sv
// Shared types for the edge-to-level rebuilder.
//   edge_e       : queued event type (1 = rise, 0 = fall), also used as a level
//   e2l_state_e  : replay FSM state
package edge_pkg;

  typedef enum logic {EDGE_FALL = 1'b0, EDGE_RISE = 1'b1} edge_e;

  typedef enum logic {ST_IDLE, ST_HOLD} e2l_state_e;

endpackage

// File: rtl/edge_fifo.sv
// Small synchronous FIFO of edge events.
// Ports:
//   clk, reset      clock, async active-low reset
//   push, push_data write one event (caller guarantees !full or pop same cycle)
//   pop, pop_data   pop_data is the current head, read straight from storage
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH
// Pointers carry one extra bit so full and empty are distinguishable without wrap tricks.
module edge_fifo
  import edge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  edge_e                    push_data,
  input  logic                     pop,
  output edge_e                    pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  edge_e        mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // When full, a simultaneous push overwrites the slot being popped; the head
  // is read before the edge, so the popped value is the old one.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/edge_to_level.sv
// Rebuilds a level signal from single-cycle rise/fall pulses. Accepted events
// are queued and replayed so that every level on a_o lasts at least MIN_HOLD cycles.
// Ports:
//   clk, reset        clock, async active-low reset
//   rising_edge_i     rise event pulse
//   falling_edge_i    fall event pulse
//   clr_err_i         clears sticky err_o
//   a_o               reconstructed level
//   busy_o            queue non-empty or hold in progress
//   count_o           queue occupancy
//   err_o             sticky: an event was dropped (illegal, redundant or overflow)
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no hold running; pops the head as soon as the queue has one
// ST_HOLD | a_o changed recently; cnt counts down the remaining hold cycles
module edge_to_level
  import edge_pkg::*;
#(
  parameter int   DEPTH      = 4,
  parameter int   MIN_HOLD   = 3,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rising_edge_i,
  input  logic                     falling_edge_i,
  input  logic                     clr_err_i,
  output logic                     a_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     err_o
);

  localparam int            CW          = $clog2(MIN_HOLD + 1);
  localparam logic [CW-1:0] HOLD_RELOAD = CW'(MIN_HOLD - 1);

  e2l_state_e     state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           a_q, a_n;
  logic           tail_level;
  logic           err_q, err_n;

  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  edge_e          ev_type, head;

  logic           one_pulse, illegal, redundant, overflow;

  // Accept logic
  always_comb begin
    one_pulse = rising_edge_i ^ falling_edge_i;
    ev_type   = rising_edge_i ? EDGE_RISE : EDGE_FALL;
    illegal   = rising_edge_i & falling_edge_i;
    redundant = one_pulse & (logic'(ev_type) == tail_level);
    // A pop in the same cycle frees a slot, so full only drops without one.
    overflow  = one_pulse & ~redundant & fifo_full & ~fifo_pop;
    fifo_push = one_pulse & ~redundant & ~overflow;
    err_n     = (illegal | redundant | overflow) | (err_q & ~clr_err_i);
  end

  // Replay FSM
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    a_n      = a_q;
    fifo_pop = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          a_n      = logic'(head);
          cnt_n    = HOLD_RELOAD;
          state_n  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          a_n      = logic'(head);
          cnt_n    = HOLD_RELOAD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      a_q        <= INIT_LEVEL;
      tail_level <= INIT_LEVEL;
      err_q      <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      a_q   <= a_n;
      err_q <= err_n;
      if (fifo_push) tail_level <= logic'(ev_type);
    end
  end

  edge_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (ev_type),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count_o)
  );

  assign a_o    = a_q;
  assign err_o  = err_q;
  assign busy_o = (state == ST_HOLD) | (count_o != '0);

endmodule

// File: tb/tb_edge_to_level.sv
module tb_edge_to_level;

  localparam int DEPTH    = 4;
  localparam int MIN_HOLD = 3;

  logic       clk;
  logic       reset;
  logic       rise, fall, clr;
  logic       a_o, busy_o, err_o;
  logic [2:0] count_o;

  int checks = 0;
  int errors = 0;

  edge_to_level #(.DEPTH(DEPTH), .MIN_HOLD(MIN_HOLD), .INIT_LEVEL(1'b0)) dut (
    .clk            (clk),
    .reset          (reset),
    .rising_edge_i  (rise),
    .falling_edge_i (fall),
    .clr_err_i      (clr),
    .a_o            (a_o),
    .busy_o         (busy_o),
    .count_o        (count_o),
    .err_o          (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of pending levels plus the time of the last change.
  int q[$];
  int m_a, m_tail, m_err, m_holding, m_t_change, edge_n;

  task automatic model_reset();
    q.delete();
    m_a = 0; m_tail = 0; m_err = 0; m_holding = 0; m_t_change = 0; edge_n = 0;
  endtask

  task automatic model_edge(input int r, input int f, input int c);
    int  ty;
    bit  do_pop, bad;
    edge_n++;
    do_pop = (q.size() > 0) && (!m_holding || (edge_n - m_t_change >= MIN_HOLD));
    ty  = r;
    bad = 0;
    if (r && f) bad = 1;
    else if (r || f) begin
      if (ty == m_tail) bad = 1;
      else if (q.size() == DEPTH && !do_pop) bad = 1;
    end
    if (do_pop) begin
      m_a = q.pop_front();
      m_t_change = edge_n;
      m_holding = 1;
    end else if (m_holding && (edge_n - m_t_change >= MIN_HOLD)) begin
      m_holding = 0;
    end
    if ((r ^ f) && !bad) begin
      q.push_back(ty);
      m_tail = ty;
    end
    if (bad) m_err = 1;
    else if (c) m_err = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a_o"},     32'(a_o),     32'(m_a));
    chk({tag, ".busy_o"},  32'(busy_o),  32'((m_holding != 0) || (q.size() != 0)));
    chk({tag, ".count_o"}, 32'(count_o), 32'(q.size()));
    chk({tag, ".err_o"},   32'(err_o),   32'(m_err));
  endtask

  task automatic cycle(input int r, input int f, input int c, input string tag);
    @(negedge clk);
    rise = 1'(r); fall = 1'(f); clr = 1'(c);
    @(posedge clk);
    model_edge(r, f, c);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    rise = 1'b0; fall = 1'b0; clr = 1'b0;
    model_reset();
    #1 check_all({tag, ".rst"});
    repeat (3) begin
      @(posedge clk);
      #1 check_all({tag, ".rst"});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, tag);
  endtask

  initial begin
    reset = 1'b0; rise = 1'b0; fall = 1'b0; clr = 1'b0;
    model_reset();

    // Single rise
    do_reset("rise");
    cycle(1, 0, 0, "rise.e1");
    cycle(0, 0, 0, "rise.e2");
    chk("rise.a_at_e2", 32'(a_o), 32'd1);
    idle(4, "rise.tail");
    chk("rise.busy_done", 32'(busy_o), 32'd0);

    // Rise then fall
    do_reset("rf");
    cycle(1, 0, 0, "rf.e1");
    cycle(0, 1, 0, "rf.e2");
    idle(2, "rf.hold");
    chk("rf.a_at_e4", 32'(a_o), 32'd1);
    cycle(0, 0, 0, "rf.e5");
    chk("rf.a_at_e5", 32'(a_o), 32'd0);
    idle(4, "rf.tail");

    // Illegal simultaneous pulses, then clear
    do_reset("ill");
    cycle(1, 1, 0, "ill.e1");
    chk("ill.err_e1", 32'(err_o), 32'd1);
    cycle(0, 0, 0, "ill.e2");
    cycle(0, 0, 1, "ill.e3");
    chk("ill.err_cleared", 32'(err_o), 32'd0);

    // Redundant rise
    do_reset("red");
    cycle(1, 0, 0, "red.e1");
    cycle(1, 0, 0, "red.e2");
    idle(4, "red.tail");

    // Overflow, then reset mid-operation
    do_reset("ovf");
    for (int i = 0; i < 7; i++) begin
      cycle((i % 2 == 0) ? 1 : 0, (i % 2 == 0) ? 0 : 1, 0, "ovf.ev");
      if (i == 5) chk("ovf.count_e6", 32'(count_o), 32'd4);
    end
    chk("ovf.err_e7", 32'(err_o), 32'd1);
    cycle(0, 0, 0, "ovf.e8");
    #2 reset = 1'b0;
    model_reset();
    #1 check_all("ovf.async_rst");
    chk("ovf.rst_count", 32'(count_o), 32'd0);
    do_reset("ovf2");

    // Error set and clear in the same cycle: the error wins
    cycle(1, 1, 1, "clrwin");
    idle(2, "clrwin.tail");

    // Randomized traffic with occasional mid-operation resets
    for (int n = 0; n < 3000; n++) begin
      int p, r, f, c;
      p = int'($urandom_range(0, 99));
      r = (p < 35) ? 1 : 0;
      f = (p >= 30 && p < 65) ? 1 : 0;
      c = ($urandom_range(0, 19) == 0) ? 1 : 0;
      cycle(r, f, c, "rnd");
      if ($urandom_range(0, 499) == 0) begin
        #3 reset = 1'b0;
        model_reset();
        #1 check_all("rnd.async_rst");
        do_reset("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
